fill_rect: RTL and testbench

FILL_RECT -- requirements
Module: fill_rect

---
 rtl/fill_rect.sv | 130 +++++++++++++
 tb/tb_fill_rect.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_rect.sv
// Rectangle fill engine: latches a rectangle, then writes it column-major one pixel per cycle.
// Define FILL_RECT_CLIP_EN to clamp the rectangle to the screen during LOAD.
module fill_rect #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour,
  input  logic          mode,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);

  typedef enum logic [1:0] {StIdle, StLoad, StFill, StDone} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x0_q, x1_q, x_q;
  logic [YW-1:0] y0_q, y1_q, y_q;
  logic [CW-1:0] col_q;
  logic          mode_q;

  logic [XW-1:0] x1_eff;
  logic [YW-1:0] y1_eff;
  logic          empty;
  logic          last_px;
  logic          in_screen;

`ifdef FILL_RECT_CLIP_EN
  localparam logic [XW-1:0] XMax = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] YMax = YW'(SCREEN_H - 1);

  always_comb begin
    x1_eff = (x1_q > XMax) ? XMax : x1_q;
    y1_eff = (y1_q > YMax) ? YMax : y1_q;
    empty  = (32'(x0_q) >= SCREEN_W) || (32'(y0_q) >= SCREEN_H) ||
             (x0_q > x1_eff) || (y0_q > y1_eff);
  end
`else
  always_comb begin
    x1_eff = x1_q;
    y1_eff = y1_q;
    empty  = (x0_q > x1_q) || (y0_q > y1_q);
  end
`endif

  // Terminal test is equality so x1/y1 at the top of the counter range cannot wrap.
  assign last_px   = (x_q == x1_q) && (y_q == y1_q);
  assign in_screen = (32'(x_q) < SCREEN_W) && (32'(y_q) < SCREEN_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = empty ? StDone : StFill;
      StFill:  if (last_px) state_d = StDone;
      StDone:  if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q   <= '0;
      x1_q   <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      col_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x0_q   <= x0;
            x1_q   <= x1;
            y0_q   <= y0;
            y1_q   <= y1;
            col_q  <= colour;
            mode_q <= mode;
          end
        end
        StLoad: begin
          x1_q <= x1_eff;
          y1_q <= y1_eff;
          x_q  <= x0_q;
          y_q  <= y0_q;
        end
        StFill: begin
          if (y_q == y1_q) begin
            y_q <= y0_q;
            if (x_q != x1_q) x_q <= x_q + 1'b1;
          end else begin
            y_q <= y_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done       = (state_q == StDone);
    vga_plot   = (state_q == StFill) && in_screen;
    vga_x      = x_q;
    vga_y      = y_q;
    vga_colour = mode_q ? (col_q + CW'(x_q - x0_q)) : col_q;
  end

endmodule

// File: tb/tb_fill_rect.sv
// Self-checking bench for fill_rect: per-cycle comparison against a pixel-list reference model.
module tb_fill_rect;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic          clk, rst, start, mode, done, vga_plot;
  logic [XW-1:0] x0, x1, vga_x;
  logic [YW-1:0] y0, y1, vga_y;
  logic [CW-1:0] colour, vga_colour;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit plot;
    int x;
    int y;
    int c;
  } ent_t;

  ent_t exp_q[$];
  int   obs_x[$];
  int   obs_y[$];
  int   obs_c[$];

  fill_rect #(
    .SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .YW(YW), .CW(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .colour    (colour),
    .mode      (mode),
    .done      (done),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list every FILL cycle the rectangle should take, in column-major order.
  task automatic build_model(input int ax0, ax1, ay0, ay1, acol, input bit amode);
    int ex1, ey1;
    bit emp;
    ent_t e;
    exp_q.delete();
    ex1 = ax1;
    ey1 = ay1;
    emp = 0;
`ifdef FILL_RECT_CLIP_EN
    if (ax0 >= SW || ay0 >= SH) emp = 1;
    if (ex1 > SW - 1) ex1 = SW - 1;
    if (ey1 > SH - 1) ey1 = SH - 1;
`endif
    if (ax0 > ex1 || ay0 > ey1) emp = 1;
    if (!emp) begin
      for (int x = ax0; x <= ex1; x++) begin
        for (int y = ay0; y <= ey1; y++) begin
          e.plot = (x < SW) && (y < SH);
          e.x    = x;
          e.y    = y;
          e.c    = amode ? (acol + x - ax0) % (1 << CW) : acol;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_fill(input string name, input int ax0, ax1, ay0, ay1, acol,
                          input bit amode, input bit scramble);
    build_model(ax0, ax1, ay0, ay1, acol, amode);
    obs_x.delete();
    obs_y.delete();
    obs_c.delete();
    @(negedge clk);
    x0     = XW'(ax0);
    x1     = XW'(ax1);
    y0     = YW'(ay0);
    y1     = YW'(ay1);
    colour = CW'(acol);
    mode   = amode;
    start  = 1'b1;
    @(posedge clk);
    #1;
    if (scramble) begin
      x0     = XW'($urandom);
      x1     = XW'($urandom);
      y0     = YW'($urandom);
      y1     = YW'($urandom);
      colour = CW'($urandom);
      mode   = 1'($urandom);
    end
    checks++;
    if (vga_plot !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s load: plot=%b done=%b, required 0 0", name, vga_plot, done);
    end
    foreach (exp_q[i]) begin
      @(posedge clk);
      #1;
      checks++;
      if (vga_plot !== exp_q[i].plot) begin
        errors++;
        $display("FAIL %s plot[%0d]: got %b, required %b at (%0d,%0d)", name, i, vga_plot,
                 exp_q[i].plot, exp_q[i].x, exp_q[i].y);
      end else if (exp_q[i].plot) begin
        checks++;
        if (vga_x !== XW'(exp_q[i].x) || vga_y !== YW'(exp_q[i].y) ||
            vga_colour !== CW'(exp_q[i].c)) begin
          errors++;
          $display("FAIL %s pixel[%0d]: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)", name, i,
                   vga_x, vga_y, vga_colour, exp_q[i].x, exp_q[i].y, exp_q[i].c);
        end
      end
      if (vga_plot === 1'b1) begin
        obs_x.push_back(int'(vga_x));
        obs_y.push_back(int'(vga_y));
        obs_c.push_back(int'(vga_colour));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got done=%b plot=%b, required 1 0", name, done, vga_plot);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_hold: got %b, required 1", name, done);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_clear: got %b, required 0", name, done);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || vga_plot !== 1'b0 || vga_x !== '0 || vga_y !== '0 ||
        vga_colour !== '0) begin
      errors++;
      $display("FAIL reset: done=%b plot=%b x=%0d y=%0d c=%0d, required all 0", done, vga_plot,
               vga_x, vga_y, vga_colour);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_pixel();
    run_fill("single", 7, 7, 9, 9, 5, 1'b0, 1'b0);
    checks++;
    if (obs_x.size() != 1 || obs_x[0] != 7 || obs_y[0] != 9) begin
      errors++;
      $display("FAIL single_count: got %0d plots, required 1 at (7,9)", obs_x.size());
    end
  endtask

  task automatic test_empty();
    run_fill("empty", 10, 5, 3, 8, 2, 1'b0, 1'b0);
    checks++;
    if (obs_x.size() != 0) begin
      errors++;
      $display("FAIL empty_count: got %0d plots, required 0", obs_x.size());
    end
  endtask

  task automatic test_stripe();
    int want[10] = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
    run_fill("stripe", 0, 9, 0, 0, 6, 1'b1, 1'b0);
    checks++;
    if (obs_c.size() != 10) begin
      errors++;
      $display("FAIL stripe_count: got %0d plots, required 10", obs_c.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (obs_c[i] != want[i]) begin
          errors++;
          $display("FAIL stripe_colour x=%0d: got %0d, required %0d", i, obs_c[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_clip();
    int bad;
    run_fill("clip", 150, 200, 110, 127, 2, 1'b0, 1'b0);
    bad = 0;
    foreach (obs_x[i]) if (obs_x[i] > 159 || obs_y[i] > 119) bad++;
    checks++;
    if (obs_x.size() != 100 || bad != 0) begin
      errors++;
      $display("FAIL clip: got %0d plots (%0d off-screen), required 100 (0)", obs_x.size(), bad);
    end
  endtask

  task automatic test_counter_limits();
    run_fill("xmax", 150, 255, 119, 119, 4, 1'b1, 1'b0);
    checks++;
    if (obs_x.size() != 10) begin
      errors++;
      $display("FAIL xmax_count: got %0d plots, required 10", obs_x.size());
    end
    run_fill("ymax", 5, 5, 100, 127, 1, 1'b0, 1'b0);
    checks++;
    if (obs_x.size() != 20) begin
      errors++;
      $display("FAIL ymax_count: got %0d plots, required 20", obs_x.size());
    end
  endtask

  task automatic test_random();
    int ax0, ax1, ay0, ay1;
    for (int n = 0; n < 24; n++) begin
      ax0 = $urandom_range(0, 200);
      ay0 = $urandom_range(0, 127);
      ax1 = ax0 + $urandom_range(0, 10);
      ay1 = ay0 + $urandom_range(0, 8);
      if (ax1 > 255) ax1 = 255;
      if (ay1 > 127) ay1 = 127;
      if ($urandom_range(0, 7) == 0 && ax0 > 0) ax1 = ax0 - 1;
      run_fill("random", ax0, ax1, ay0, ay1, $urandom_range(0, 7), 1'($urandom), 1'b1);
    end
  endtask

  task automatic test_full_screen();
    run_fill("full", 0, 159, 0, 119, 5, 1'b0, 1'b0);
    checks++;
    if (obs_x.size() != 19200) begin
      errors++;
      $display("FAIL full_count: got %0d plots, required 19200", obs_x.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int plots, stray;
    @(negedge clk);
    x0 = '0; x1 = XW'(159); y0 = '0; y1 = YW'(119); colour = 3'd5; mode = 1'b0;
    start = 1'b1;
    plots = 0;
    for (int i = 0; i < 200 && plots < 50; i++) begin
      @(posedge clk);
      #1;
      if (vga_plot === 1'b1) plots++;
    end
    checks++;
    if (plots != 50) begin
      errors++;
      $display("FAIL abort_reach: got %0d plots, required 50", plots);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (vga_plot !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: plot=%b done=%b, required 0 0", vga_plot, done);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (vga_plot !== 1'b0 || done !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_idle: got %0d active cycles, required 0", stray);
    end
    run_fill("after_abort", 3, 4, 2, 3, 6, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; colour = '0;
    test_reset();
    test_single_pixel();
    test_empty();
    test_stripe();
    test_clip();
    test_counter_limits();
    test_random();
    test_full_screen();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
